// File: rtl/sbqm_queue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sbqm_queue_ctrl                                                |
// | Function : Bank-queue sequencer: debounced entry/exit photocells, people |
// |            count, full/empty/error flags and estimated wait time.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sbqm_queue_ctrl #(
  parameter int n   = 3,
  parameter int DEB = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         front_sensor,
  input  logic         back_sensor,
  input  logic [1:0]   Tcount,
  output logic [n-1:0] Pcount,
  output logic [n+1:0] Wtime,
  output logic         full,
  output logic         empty,
  output logic         ovf_err,
  output logic         unf_err
);

  localparam int              c_cnt_w = $clog2(DEB + 1);
  localparam logic [c_cnt_w-1:0] c_deb  = c_cnt_w'(DEB);
  localparam logic [n-1:0]    c_pmax  = '1;
  localparam logic [n+2:0]    c_three = (n+3)'(3);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARMING    = 2'd1,
    S_BLOCKED   = 2'd2,
    S_RELEASING = 2'd3
  } pass_state_t;

  logic [1:0] w_sensor;
  logic [1:0] w_ev;    // [0] entry event, [1] exit event

  assign w_sensor = {back_sensor, front_sensor};

  for (genvar g = 0; g < 2; g++) begin : g_sensor
    logic [1:0]         r_sync;
    logic               w_sync;
    pass_state_t        r_state;
    pass_state_t        w_state_nx;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nx;
    logic               r_ev;
    logic               w_ev_nx;

    assign w_sync = r_sync[1];
    assign w_ev[g] = r_ev;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync  <= 2'b00;
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_ev    <= 1'b0;
      end else begin
        r_sync  <= {r_sync[0], w_sensor[g]};
        r_state <= w_state_nx;
        r_cnt   <= w_cnt_nx;
        r_ev    <= w_ev_nx;
      end
    end

    // A passage counts only once the sensor has been held blocked and then
    // held clear, each for DEB synchronized cycles.
    always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_ev_nx    = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_sync) begin
            w_state_nx = S_ARMING;
            w_cnt_nx   = c_cnt_w'(1);
          end
        end
        S_ARMING: begin
          if (!w_sync) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
          end else if (r_cnt == c_deb) begin
            w_state_nx = S_BLOCKED;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
        S_BLOCKED: begin
          if (!w_sync) begin
            w_state_nx = S_RELEASING;
            w_cnt_nx   = c_cnt_w'(1);
          end
        end
        S_RELEASING: begin
          if (w_sync) begin
            w_state_nx = S_BLOCKED;
            w_cnt_nx   = '0;
          end else if (r_cnt == c_deb) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
            w_ev_nx    = 1'b1;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  logic [n-1:0] r_pcount;
  logic [n-1:0] w_pcount_nx;
  logic         r_full;
  logic         r_empty;
  logic         r_ovf;
  logic         r_unf;
  logic         w_ovf;
  logic         w_unf;
  logic [1:0]   r_tq;
  logic [n+1:0] r_wtime;
  logic [n+2:0] w_sum;
  logic [n+2:0] w_num;
  logic [n+2:0] w_quo;
  logic [n+1:0] w_wtime;

  // Coincident entry and exit cancel out, with no error even at the limits.
  always_comb begin
    w_pcount_nx = r_pcount;
    w_ovf       = 1'b0;
    w_unf       = 1'b0;
    if (w_ev[0] && !w_ev[1]) begin
      if (r_full) w_ovf = 1'b1;
      else        w_pcount_nx = r_pcount + 1'b1;
    end else if (w_ev[1] && !w_ev[0]) begin
      if (r_empty) w_unf = 1'b1;
      else         w_pcount_nx = r_pcount - 1'b1;
    end
  end

  always_comb begin
    w_sum   = {3'b000, r_pcount} + {{(n+1){1'b0}}, r_tq} - 1'b1;
    w_num   = (w_sum << 1) + w_sum;
    w_quo   = '0;
    w_wtime = '0;
    case (r_tq)
      2'd1:    w_quo = w_num;
      2'd2:    w_quo = w_num >> 1;
      2'd3:    w_quo = w_num / c_three;
      default: w_quo = '0;
    endcase
    if (r_pcount != '0 && r_tq != 2'd0) w_wtime = w_quo[n+1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcount <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_tq     <= 2'd0;
      r_wtime  <= '0;
    end else begin
      r_pcount <= w_pcount_nx;
      r_full   <= (w_pcount_nx == c_pmax);
      r_empty  <= (w_pcount_nx == '0);
      r_ovf    <= w_ovf;
      r_unf    <= w_unf;
      r_tq     <= Tcount;
      r_wtime  <= w_wtime;
    end
  end

  assign Pcount  = r_pcount;
  assign Wtime   = r_wtime;
  assign full    = r_full;
  assign empty   = r_empty;
  assign ovf_err = r_ovf;
  assign unf_err = r_unf;

endmodule
`default_nettype wire
